image_frame_loader: RTL and testbench

Parametrised row-serial image loader and successor to the fixed 28×7 reader. It accepts NUM_ROWS rows of ROW_BITS pixels over a valid/ready stream and assembles them into a flat frame register for the classifier datapath. It adds start/abort control, a consume handshake and optional auto re-arm, so back-to-back frames are loaded without a reset pulse per image.

---
 rtl/mnist_pkg.sv | 13 +
 rtl/image_frame_loader.sv | 103 ++++++++++
 tb/tb_image_frame_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST datapath: loader state encoding and default image geometry.
package mnist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        FULL = 2'b10
    } loader_state_t;

    localparam int IMG_ROW_BITS = 7;
    localparam int IMG_ROWS     = 28;

endpackage

// File: rtl/image_frame_loader.sv
// Row-serial image loader: shifts NUM_ROWS rows from a valid/ready stream into a flat frame
// register, holds it until consumed, and supports start/abort and optional auto re-arm.
module image_frame_loader
    import mnist_pkg::*;
#(
    parameter int  ROW_BITS   = IMG_ROW_BITS,
    parameter int  NUM_ROWS   = IMG_ROWS,
    parameter int  AUTO_START = 1,
    parameter int  AUTO_REARM = 0,
    localparam int CW         = $clog2(NUM_ROWS + 1),
    localparam int FW         = ROW_BITS * NUM_ROWS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ROW_BITS-1:0] data_in,
    output logic [FW-1:0]       image_data,
    output logic                image_ready,
    output logic                frame_done,
    input  logic                consume,
    output logic [CW-1:0]       rows_loaded
);

    localparam loader_state_t RESET_STATE = (AUTO_START != 0) ? LOAD : IDLE;
    localparam logic [CW-1:0] LAST_ROW    = CW'(NUM_ROWS - 1);

    loader_state_t state_reg, state_next;
    logic [FW-1:0] image_reg, image_next;
    logic [CW-1:0] rows_reg, rows_next;
    logic          ready_reg, ready_next;
    logic          done_reg, done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RESET_STATE;
            image_reg <= '0;
            rows_reg  <= '0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            image_reg <= image_next;
            rows_reg  <= rows_next;
            ready_reg <= ready_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        image_next = image_reg;
        rows_next  = rows_reg;
        ready_next = ready_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    image_next = '0;
                    rows_next  = '0;
                end
            end
            LOAD: begin
                // start aborts the partial frame and wins over a beat in the same cycle
                if (start) begin
                    image_next = '0;
                    rows_next  = '0;
                end else if (in_valid && in_ready) begin
                    image_next = (image_reg << ROW_BITS) | FW'(data_in);
                    rows_next  = rows_reg + CW'(1);
                    if (rows_reg == LAST_ROW) begin
                        state_next = FULL;
                        ready_next = 1'b1;
                        done_next  = 1'b1;
                    end
                end
            end
            FULL: begin
                if (start || consume) begin
                    state_next = (start || AUTO_REARM != 0) ? LOAD : IDLE;
                    image_next = '0;
                    rows_next  = '0;
                    ready_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                image_next = '0;
                rows_next  = '0;
                ready_next = 1'b0;
            end
        endcase
    end

    assign in_ready    = (state_reg == LOAD);
    assign image_data  = image_reg;
    assign image_ready = ready_reg;
    assign frame_done  = done_reg;
    assign rows_loaded = rows_reg;

endmodule

// File: tb/tb_image_frame_loader.sv
// Bench for image_frame_loader: two default-geometry instances (re-arm on/off) share stimulus,
// a third small instance covers the parameter sweep; frames are checked through scoreboard queues.
module tb_image_frame_loader;

    localparam int RB = 7;
    localparam int NR = 28;
    localparam int FW = RB * NR;
    localparam int CW = $clog2(NR + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start, in_valid, consume;
    logic [RB-1:0] data_in;

    logic          in_ready_a, image_ready_a, frame_done_a;
    logic [FW-1:0] image_data_a;
    logic [CW-1:0] rows_a;
    logic          in_ready_b, image_ready_b, frame_done_b;
    logic [FW-1:0] image_data_b;
    logic [CW-1:0] rows_b;

    logic          start_c, in_valid_c, consume_c;
    logic [3:0]    data_c;
    logic          in_ready_c, image_ready_c, frame_done_c;
    logic [11:0]   image_data_c;
    logic [1:0]    rows_c;

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] sb_q[$];
    logic [11:0]   sb_c[$];
    logic [FW-1:0] mdl_img;
    int            mdl_rows;
    bit            mdl_loading;
    logic [FW-1:0] exp_img;
    logic [11:0]   exp_c;

    image_frame_loader #(.ROW_BITS(RB), .NUM_ROWS(NR), .AUTO_START(1), .AUTO_REARM(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .data_in(data_in), .image_data(image_data_a), .image_ready(image_ready_a),
        .frame_done(frame_done_a), .consume(consume), .rows_loaded(rows_a)
    );

    image_frame_loader #(.ROW_BITS(RB), .NUM_ROWS(NR), .AUTO_START(1), .AUTO_REARM(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .data_in(data_in), .image_data(image_data_b), .image_ready(image_ready_b),
        .frame_done(frame_done_b), .consume(consume), .rows_loaded(rows_b)
    );

    image_frame_loader #(.ROW_BITS(4), .NUM_ROWS(3), .AUTO_START(0), .AUTO_REARM(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .data_in(data_c), .image_data(image_data_c), .image_ready(image_ready_c),
        .frame_done(frame_done_c), .consume(consume_c), .rows_loaded(rows_c)
    );

    // One cycle of shared stimulus, applied at a falling edge; the model follows instance A.
    task automatic drive_beat(input logic v, input logic [RB-1:0] d, input logic st, input logic cons);
        start    = st;
        consume  = cons;
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        if (st) begin
            mdl_img     = '0;
            mdl_rows    = 0;
            mdl_loading = 1'b1;
        end else if (v && mdl_loading) begin
            mdl_img  = {mdl_img[FW-RB-1:0], d};
            mdl_rows = mdl_rows + 1;
            if (mdl_rows == NR) begin
                sb_q.push_back(mdl_img);
                mdl_loading = 1'b0;
            end
        end else if (cons && !mdl_loading) begin
            mdl_img     = '0;
            mdl_rows    = 0;
            mdl_loading = 1'b1;
        end
        @(negedge clk);
        start    = 1'b0;
        consume  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; in_valid = 1'b0; consume = 1'b0; data_in = '0;
        start_c = 1'b0; in_valid_c = 1'b0; consume_c = 1'b0; data_c = '0;
        mdl_img = '0; mdl_rows = 0; mdl_loading = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rows_a !== '0) begin errors++; $display("FAIL reset_rows: got %0d expected 0", rows_a); end
        checks++; if (image_data_a !== '0) begin errors++; $display("FAIL reset_image: got %h expected 0", image_data_a); end
        checks++; if (image_ready_a !== 1'b0) begin errors++; $display("FAIL reset_image_ready: got %b expected 0", image_ready_a); end
        checks++; if (frame_done_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done_a); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready_autostart: got %b expected 1", in_ready_a); end
        checks++; if (in_ready_c !== 1'b0) begin errors++; $display("FAIL reset_in_ready_idle: got %b expected 0", in_ready_c); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready_b); end
        $display("test_reset done");
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < NR - 1; i++) drive_beat(1'b1, 7'h01, 1'b0, 1'b0);
        checks++; if (image_ready_a !== 1'b0) begin errors++; $display("FAIL full_early_ready: got %b expected 0", image_ready_a); end
        checks++; if (rows_a !== CW'(mdl_rows)) begin errors++; $display("FAIL full_rows_27: got %0d expected %0d", rows_a, mdl_rows); end
        drive_beat(1'b1, 7'h01, 1'b0, 1'b0);
        checks++; if (frame_done_a !== 1'b1) begin errors++; $display("FAIL full_frame_done: got %b expected 1", frame_done_a); end
        checks++; if (image_ready_a !== 1'b1) begin errors++; $display("FAIL full_image_ready: got %b expected 1", image_ready_a); end
        checks++; if (rows_a !== CW'(NR)) begin errors++; $display("FAIL full_rows: got %0d expected %0d", rows_a, NR); end
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready_a); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL full_scoreboard: got empty queue expected 1 frame"); end
        else begin
            exp_img = sb_q.pop_front();
            if (image_data_a !== exp_img) begin errors++; $display("FAIL full_image_a: got %h expected %h", image_data_a, exp_img); end
            checks++; if (image_data_b !== exp_img) begin errors++; $display("FAIL full_image_b: got %h expected %h", image_data_b, exp_img); end
        end
        drive_beat(1'b0, '0, 1'b0, 1'b0);
        checks++; if (frame_done_a !== 1'b0) begin errors++; $display("FAIL full_done_pulse: got %b expected 0", frame_done_a); end
        checks++; if (image_ready_a !== 1'b1) begin errors++; $display("FAIL full_ready_level: got %b expected 1", image_ready_a); end
        $display("test_full_frame done");
    endtask

    task automatic test_rearm();
        drive_beat(1'b0, '0, 1'b0, 1'b1);
        checks++; if (image_ready_a !== 1'b0) begin errors++; $display("FAIL rearm_ready_a: got %b expected 0", image_ready_a); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rearm_in_ready_a: got %b expected 1", in_ready_a); end
        checks++; if (image_data_a !== '0) begin errors++; $display("FAIL rearm_image_clear: got %h expected 0", image_data_a); end
        checks++; if (image_ready_b !== 1'b0) begin errors++; $display("FAIL noarm_ready_b: got %b expected 0", image_ready_b); end
        checks++; if (in_ready_b !== 1'b0) begin errors++; $display("FAIL noarm_in_ready_b: got %b expected 0", in_ready_b); end
        for (int i = 0; i < NR; i++) drive_beat(1'b1, 7'h2A, 1'b0, 1'b0);
        checks++; if (frame_done_a !== 1'b1) begin errors++; $display("FAIL rearm_frame_done: got %b expected 1", frame_done_a); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL rearm_scoreboard: got empty queue expected 1 frame"); end
        else begin
            exp_img = sb_q.pop_front();
            if (image_data_a !== exp_img) begin errors++; $display("FAIL rearm_image: got %h expected %h", image_data_a, exp_img); end
        end
        checks++; if (rows_b !== '0) begin errors++; $display("FAIL idle_rows_b: got %0d expected 0", rows_b); end
        checks++; if (in_ready_b !== 1'b0) begin errors++; $display("FAIL idle_in_ready_b: got %b expected 0", in_ready_b); end
        drive_beat(1'b0, '0, 1'b1, 1'b0);
        checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL idle_start_b: got %b expected 1", in_ready_b); end
        checks++; if (image_ready_a !== 1'b0) begin errors++; $display("FAIL full_start_a: got %b expected 0", image_ready_a); end
        $display("test_rearm done");
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 200 && mdl_loading; i++) begin
            drive_beat((i % 2) == 0, 7'h7F, 1'b0, 1'b0);
            if (i == 9) begin
                checks++; if (rows_a !== CW'(5)) begin errors++; $display("FAIL gap_rows_mid: got %0d expected 5", rows_a); end
            end
        end
        checks++; if (frame_done_a !== 1'b1) begin errors++; $display("FAIL gap_frame_done: got %b expected 1", frame_done_a); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL gap_scoreboard: got empty queue expected 1 frame"); end
        else begin
            exp_img = sb_q.pop_front();
            if (image_data_b !== exp_img) begin errors++; $display("FAIL gap_image_b: got %h expected %h", image_data_b, exp_img); end
        end
        for (int i = 0; i < 3; i++) drive_beat(1'b1, 7'h11, 1'b0, 1'b0);
        checks++; if (rows_a !== CW'(NR)) begin errors++; $display("FAIL gap_full_rows: got %0d expected %0d", rows_a, NR); end
        checks++; if (image_data_a !== exp_img) begin errors++; $display("FAIL gap_full_frozen: got %h expected %h", image_data_a, exp_img); end
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL gap_full_in_ready: got %b expected 0", in_ready_a); end
        drive_beat(1'b0, '0, 1'b0, 1'b1);
        drive_beat(1'b0, '0, 1'b1, 1'b0);
        $display("test_gapped done");
    endtask

    task automatic test_abort();
        for (int i = 0; i < 10; i++) drive_beat(1'b1, 7'h13, 1'b0, 1'b0);
        checks++; if (rows_a !== CW'(10)) begin errors++; $display("FAIL abort_rows_10: got %0d expected 10", rows_a); end
        drive_beat(1'b1, 7'h55, 1'b1, 1'b0);
        checks++; if (rows_a !== '0) begin errors++; $display("FAIL abort_rows: got %0d expected 0", rows_a); end
        checks++; if (image_data_a !== '0) begin errors++; $display("FAIL abort_image: got %h expected 0", image_data_a); end
        checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready_b); end
        for (int i = 0; i < NR; i++) drive_beat(1'b1, 7'(i * 5 + 3), 1'b0, 1'b0);
        checks++; if (image_ready_a !== 1'b1) begin errors++; $display("FAIL abort_refill_ready: got %b expected 1", image_ready_a); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL abort_scoreboard: got empty queue expected 1 frame"); end
        else begin
            exp_img = sb_q.pop_front();
            if (image_data_a !== exp_img) begin errors++; $display("FAIL abort_image_refill: got %h expected %h", image_data_a, exp_img); end
        end
        $display("test_abort done");
    endtask

    task automatic test_start_in_full();
        drive_beat(1'b0, '0, 1'b1, 1'b1);
        checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL start_consume_b: got %b expected 1", in_ready_b); end
        checks++; if (image_ready_b !== 1'b0) begin errors++; $display("FAIL start_consume_ready: got %b expected 0", image_ready_b); end
        checks++; if (rows_b !== '0) begin errors++; $display("FAIL start_consume_rows: got %0d expected 0", rows_b); end
        $display("test_start_in_full done");
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 15; i++) drive_beat(1'b1, 7'(i + 1), 1'b0, 1'b0);
        checks++; if (rows_a !== CW'(15)) begin errors++; $display("FAIL mid_rows_15: got %0d expected 15", rows_a); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (rows_a !== '0) begin errors++; $display("FAIL mid_reset_rows: got %0d expected 0", rows_a); end
        checks++; if (image_data_a !== '0) begin errors++; $display("FAIL mid_reset_image: got %h expected 0", image_data_a); end
        checks++; if (image_ready_b !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0", image_ready_b); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready_a); end
        @(negedge clk);
        reset_n = 1'b1;
        mdl_img = '0; mdl_rows = 0; mdl_loading = 1'b1;
        $display("test_reset_midframe done");
    endtask

    task automatic test_param_sweep();
        logic [3:0] rows_tbl [3];
        rows_tbl[0] = 4'hA; rows_tbl[1] = 4'hB; rows_tbl[2] = 4'hC;
        checks++; if (in_ready_c !== 1'b0) begin errors++; $display("FAIL sweep_idle: got %b expected 0", in_ready_c); end
        start_c = 1'b1;
        @(posedge clk); @(negedge clk);
        start_c = 1'b0;
        checks++; if (in_ready_c !== 1'b1) begin errors++; $display("FAIL sweep_start: got %b expected 1", in_ready_c); end
        exp_c = '0;
        for (int i = 0; i < 3; i++) begin
            exp_c = {exp_c[7:0], rows_tbl[i]};
            if (i == 2) sb_c.push_back(exp_c);
            in_valid_c = 1'b1;
            data_c     = rows_tbl[i];
            @(posedge clk); @(negedge clk);
            in_valid_c = 1'b0;
            if (i == 1) begin
                checks++; if (image_ready_c !== 1'b0) begin errors++; $display("FAIL sweep_early_ready: got %b expected 0", image_ready_c); end
                checks++; if (rows_c !== 2'd2) begin errors++; $display("FAIL sweep_rows_2: got %0d expected 2", rows_c); end
            end
        end
        checks++; if (image_ready_c !== 1'b1) begin errors++; $display("FAIL sweep_ready: got %b expected 1", image_ready_c); end
        checks++; if (frame_done_c !== 1'b1) begin errors++; $display("FAIL sweep_done: got %b expected 1", frame_done_c); end
        checks++;
        if (sb_c.size() == 0) begin errors++; $display("FAIL sweep_scoreboard: got empty queue expected 1 frame"); end
        else begin
            exp_c = sb_c.pop_front();
            if (image_data_c !== exp_c) begin errors++; $display("FAIL sweep_image: got %h expected %h", image_data_c, exp_c); end
        end
        $display("test_param_sweep done");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_rearm();
        test_gapped();
        test_abort();
        test_start_in_full();
        test_reset_midframe();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
